// File: rtl/rr_demux_pkg.sv
// rr_demux_pkg: shared constants, credit type and one-hot helper for the rr_demux_sched slice.
package rr_demux_pkg;
  localparam int NCH = 4;
  localparam int SELW = 2;
  localparam int CW = 4;
  typedef logic [CW-1:0] credit_t;
  function automatic logic [NCH-1:0] onehot4(input logic [SELW-1:0] sel);
    return 4'b0001 << sel;
  endfunction
endpackage

// File: rtl/rr_demux_sched_pick4.sv
// rr_pick4: combinational rotating-priority picker; grants first request at or after ptr.
module rr_pick4
  import rr_demux_pkg::*;
(
  input  logic [SELW-1:0] ptr,
  input  logic [NCH-1:0]  req,
  output logic [SELW-1:0] gnt,
  output logic            any
);
  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;
  logic [SELW-1:0]  off;
  // rot[k] is req[(ptr+k) mod 4], so a fixed priority encoder gives the offset from ptr
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NCH-1:0];
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign gnt = ptr + off;
  assign any = |req;
endmodule

// File: rtl/rr_demux_sched.sv
// rr_demux_sched: credit-based round-robin 1-to-4 demux scheduler.
// Optional per-channel dispatch counters when RR_DEMUX_STATS_EN is defined.
module rr_demux_sched
  import rr_demux_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int CREDITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NCH-1:0]   ch_en,
  input  logic [NCH-1:0]   credit_ret,
  output logic [SELW-1:0]  sel,
  output logic [WIDTH-1:0] out_data,
  output logic [NCH-1:0]   out_valid,
  output logic             cred_err
`ifdef RR_DEMUX_STATS_EN
  ,
  output logic [31:0]      dispatch_cnt
`endif
);
  localparam credit_t FULL = credit_t'(CREDITS);
  credit_t [NCH-1:0] credit_q, credit_d;
  logic [NCH-1:0]   elig, dec, full, valid_q, valid_d;
  logic [SELW-1:0]  gnt, ptr_q, ptr_d, sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             any, xfer, err_q, err_d;
  rr_pick4 u_pick (
    .ptr(ptr_q),
    .req(elig),
    .gnt(gnt),
    .any(any)
  );
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign elig[i] = ch_en[i] && (credit_q[i] != '0);
    assign dec[i]  = xfer && (gnt == SELW'(i));
    assign full[i] = credit_q[i] == FULL;
    // a return with no dispatch on an already-full channel is dropped and flagged
    assign credit_d[i] = (dec[i] && !credit_ret[i]) ? credit_q[i] - 1'b1 :
                         (credit_ret[i] && !dec[i] && !full[i]) ? credit_q[i] + 1'b1 :
                         credit_q[i];
  end
  assign in_ready = any;
  assign xfer     = in_valid && any;
  assign err_d    = err_q || |(credit_ret & ~dec & full);
  assign ptr_d    = xfer ? gnt + 2'd1 : ptr_q;
  assign sel_d    = xfer ? gnt : sel_q;
  assign data_d   = xfer ? in_data : data_q;
  assign valid_d  = xfer ? onehot4(gnt) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= {NCH{FULL}};
      ptr_q    <= '0;
      sel_q    <= '0;
      data_q   <= '0;
      valid_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end
  assign sel       = sel_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign cred_err  = err_q;
`ifdef RR_DEMUX_STATS_EN
  logic [NCH-1:0][7:0] cnt_q, cnt_d;
  for (genvar i = 0; i < NCH; i++) begin : g_cnt
    assign cnt_d[i] = cnt_q[i] + {7'd0, dec[i]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign dispatch_cnt = cnt_q;
`endif
endmodule
